// File: rtl/ibex_data_mem_bridge_if.sv
// LSU data-port bundle: req/gnt/rvalid handshake with address, store data and response.
interface ibex_data_mem_bridge_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/ibex_data_mem_bridge.sv
// LSU data port to single-port sync SRAM bridge with wait states and shared-port arbitration.
// DMEM_BRIDGE_ERR_EN: out-of-window accesses answer with err instead of aliasing into the SRAM.
module ibex_data_mem_bridge #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    localparam int unsigned AW         = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ibex_data_mem_bridge_if.slave bus,
    input  logic                  mem_gnt,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [AW-1:0]         mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WS_MAX = 4'(WAIT_CYCLES);

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [3:0]  ws_q;
    logic        we_q;
    logic        err_q;
    logic        err_d;
    logic        hit;
    logic [31:0] off;

    assign bus.gnt = bus.req & mem_gnt & (ws_q == WS_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_q <= 4'd0;
        end else if (!bus.req || bus.gnt) begin
            ws_q <= 4'd0;
        end else if (ws_q != WS_MAX) begin
            ws_q <= ws_q + 4'd1;
        end
    end

    // Next state depends only on this cycle's handshake, also from RESP
    always_comb begin
        state_d = IDLE;
        unique case (1'b1)
            bus.gnt:             state_d = RESP;
            bus.req && !bus.gnt: state_d = WAIT;
            !bus.req:            state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.gnt) begin
                we_q  <= bus.we;
                err_q <= err_d;
            end
        end
    end

`ifdef DMEM_BRIDGE_ERR_EN
    logic [32:0] a33;
    logic [32:0] lo33;
    logic [32:0] hi33;

    assign a33   = {1'b0, bus.addr};
    assign lo33  = {1'b0, ADDR_BASE};
    assign hi33  = lo33 + (33'(MEM_WORDS) << 2);
    assign hit   = (a33 >= lo33) && (a33 < hi33);
    assign err_d = ~hit;
`else
    assign hit   = 1'b1;
    assign err_d = 1'b0;
`endif

    assign off       = bus.addr - ADDR_BASE;
    assign mem_cs    = bus.gnt & hit;
    assign mem_we    = bus.we;
    assign mem_be    = bus.be;
    assign mem_wdata = bus.wdata;
    assign mem_addr  = AW'(off >> 2);

    assign bus.rvalid = (state_q == RESP);
    assign bus.err    = bus.rvalid & err_q;
    assign bus.rdata  = (bus.rvalid && !we_q && !err_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_ibex_data_mem_bridge.sv
// Self-checking bench: two bridges (0 and 2 wait states) against a word-array reference model.
module tb_ibex_data_mem_bridge;

`ifdef DMEM_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        req [2];
    logic        mgnt [2];
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        gnt [2];
    logic        rvalid [2];
    logic        err [2];
    logic [31:0] rdata [2];
    logic        cs [2];
    logic        mwe [2];
    logic [3:0]  mbe [2];
    logic [9:0]  maddr [2];
    logic [31:0] mwdata [2];
    logic [31:0] mrdata [2];

    logic [31:0] sram [2][1024];
    logic [31:0] refm [2][16];

    ibex_data_mem_bridge_if bus0 ();
    ibex_data_mem_bridge_if bus1 ();

    assign bus0.req   = req[0];
    assign bus0.addr  = addr;
    assign bus0.we    = we;
    assign bus0.be    = be;
    assign bus0.wdata = wdata;
    assign bus1.req   = req[1];
    assign bus1.addr  = addr;
    assign bus1.we    = we;
    assign bus1.be    = be;
    assign bus1.wdata = wdata;

    assign gnt[0]    = bus0.gnt;
    assign rvalid[0] = bus0.rvalid;
    assign err[0]    = bus0.err;
    assign rdata[0]  = bus0.rdata;
    assign gnt[1]    = bus1.gnt;
    assign rvalid[1] = bus1.rvalid;
    assign err[1]    = bus1.err;
    assign rdata[1]  = bus1.rdata;

    ibex_data_mem_bridge #(
        .ADDR_BASE(32'h0), .MEM_WORDS(1024), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .mem_gnt(mgnt[0]), .mem_cs(cs[0]), .mem_we(mwe[0]),
        .mem_be(mbe[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0])
    );

    ibex_data_mem_bridge #(
        .ADDR_BASE(32'h0), .MEM_WORDS(1024), .WAIT_CYCLES(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .mem_gnt(mgnt[1]), .mem_cs(cs[1]), .mem_we(mwe[1]),
        .mem_be(mbe[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1])
    );

    // Behavioural single-port SRAMs with 1-cycle read latency
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cs[k]) begin
                if (mwe[k]) begin
                    for (int i = 0; i < 4; i++)
                        if (mbe[k][i])
                            sram[k][maddr[k]][8*i +: 8] <= mwdata[k][8*i +: 8];
                end else begin
                    mrdata[k] <= sram[k][maddr[k]];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access; grant expected once both the wait count and arbiter allow it
    task automatic access(input int d, input logic [31:0] a, input logic st,
                          input logic [3:0] b, input logic [31:0] wd,
                          input int stall, output logic [31:0] got);
        int w;
        int tg;
        logic oor;
        logic [3:0] idx;
        logic [31:0] exp_rd;
        logic exp_err;
        w = (d == 0) ? 0 : 2;
        tg = (stall > w) ? stall : w;
        oor = ERR_EN && (a >= 32'h1000);
        idx = a[5:2];
        exp_err = oor;
        exp_rd = (st || oor) ? 32'd0 : refm[d][idx];
        if (st && !oor)
            for (int i = 0; i < 4; i++)
                if (b[i]) refm[d][idx][8*i +: 8] = wd[8*i +: 8];
        @(posedge clk); #1;
        req[d] = 1'b1;
        addr = a;
        we = st;
        be = b;
        wdata = wd;
        for (int n = 0; n < 24; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            mgnt[d] = (n >= stall);
            @(negedge clk);
            chk("gnt", {31'd0, gnt[d]}, {31'd0, n == tg});
            chk("cs", {31'd0, cs[d]}, {31'd0, (n == tg) && !oor});
            chk("rvalid_idle", {31'd0, rvalid[d]}, 32'd0);
            if (gnt[d] !== 1'b0) break;
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
        mgnt[d] = 1'b1;
        @(negedge clk);
        chk("rvalid", {31'd0, rvalid[d]}, 32'd1);
        chk("err", {31'd0, err[d]}, {31'd0, exp_err});
        chk("rdata", rdata[d], exp_rd);
        got = rdata[d];
    endtask

    initial begin
        logic [31:0] got;
        req[0] = 1'b0; req[1] = 1'b0;
        mgnt[0] = 1'b1; mgnt[1] = 1'b1;
        addr = 32'd0; we = 1'b0; be = 4'h0; wdata = 32'd0;

        #12;
        for (int k = 0; k < 2; k++) begin
            chk("rst_gnt", {31'd0, gnt[k]}, 32'd0);
            chk("rst_rvalid", {31'd0, rvalid[k]}, 32'd0);
            chk("rst_err", {31'd0, err[k]}, 32'd0);
            chk("rst_rdata", rdata[k], 32'd0);
            chk("rst_cs", {31'd0, cs[k]}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                access(d, 32'(i * 4), 1'b1, 4'hF, $urandom, 0, got);

        access(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 0, got);
        access(0, 32'h10, 1'b0, 4'h0, 32'h0, 0, got);
        chk("load_deadbeef", got, 32'hDEADBEEF);

        access(0, 32'h20, 1'b1, 4'hF, 32'h11223344, 0, got);
        access(0, 32'h20, 1'b1, 4'b0100, 32'h00AA0000, 0, got);
        access(0, 32'h20, 1'b0, 4'h0, 32'h0, 0, got);
        chk("byte_merge", got, 32'h11AA3344);

        // Withdrawn request must restart the wait count
        @(posedge clk); #1;
        req[1] = 1'b1; addr = 32'h10; we = 1'b0;
        @(negedge clk);
        chk("ws_first", {31'd0, gnt[1]}, 32'd0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("ws_drop", {31'd0, gnt[1]}, 32'd0);
        access(1, 32'h10, 1'b0, 4'h0, 32'h0, 0, got);

        access(0, 32'h14, 1'b0, 4'h0, 32'h0, 5, got);
        access(1, 32'h18, 1'b0, 4'h0, 32'h0, 5, got);

        // Back-to-back: second request granted in the RESP cycle
        @(posedge clk); #1;
        req[0] = 1'b1; addr = 32'h1C; we = 1'b0;
        @(negedge clk);
        chk("b2b_gnt1", {31'd0, gnt[0]}, 32'd1);
        @(posedge clk); #1;
        addr = 32'h20;
        @(negedge clk);
        chk("b2b_rv1", {31'd0, rvalid[0]}, 32'd1);
        chk("b2b_rd1", rdata[0], refm[0][7]);
        chk("b2b_gnt2", {31'd0, gnt[0]}, 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        chk("b2b_rv2", {31'd0, rvalid[0]}, 32'd1);
        chk("b2b_rd2", rdata[0], refm[0][8]);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_rv3", {31'd0, rvalid[0]}, 32'd0);

        access(0, 32'h0001_0000, 1'b0, 4'h0, 32'h0, 0, got);
        access(1, 32'h1004, 1'b1, 4'h3, 32'hCAFEF00D, 0, got);
        access(1, 32'h0004, 1'b0, 4'h0, 32'h0, 0, got);

        // Reset while waiting for grant
        @(posedge clk); #1;
        req[1] = 1'b1; addr = 32'h10; we = 1'b0;
        @(negedge clk);
        chk("rw_gnt", {31'd0, gnt[1]}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_gnt_rst", {31'd0, gnt[1]}, 32'd0);
        chk("rw_rv_rst", {31'd0, rvalid[1]}, 32'd0);
        chk("rw_cs_rst", {31'd0, cs[1]}, 32'd0);
        chk("rw_rd_rst", rdata[1], 32'd0);
        req[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rw_stray", {31'd0, rvalid[1]}, 32'd0);
        end

        // Reset between grant and response drops the response
        @(posedge clk); #1;
        req[0] = 1'b1; addr = 32'h10; we = 1'b0;
        @(negedge clk);
        chk("rr_gnt", {31'd0, gnt[0]}, 32'd1);
        #2 rst_n = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        chk("rr_rv", {31'd0, rvalid[0]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_stray", {31'd0, rvalid[0]}, 32'd0);

        for (int t = 0; t < 60; t++) begin
            int d;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
            access(d, a, 1'($urandom_range(0, 1)),
                   4'($urandom_range(1, 15)), $urandom,
                   int'($urandom_range(0, 3)), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
